// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage MIPS core: load-use bubbles, taken-branch
// flushes, data-memory wait states with timeout, and saturating event counters.
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_use_rt,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             pipe_en,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // state    | meaning
    // RUN      | pipeline advancing, hazards resolved combinationally
    // MEM_WAIT | data memory busy, whole pipeline frozen
    // ERR      | memory timed out, frozen until reset
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic                load_use;
    logic                advance;
    logic                stall_inc, flush_inc;

    assign load_use = idex_memread && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (ifid_use_rt && (idex_rt == ifid_rt)));

    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        advance     = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        pipe_en     = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;

        case (state)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end else begin
                    advance = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                    if (wait_cnt == WAIT_W'(TIMEOUT - 1))
                        state_nxt = ERR;
                end else begin
                    advance   = 1'b1;
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ERR;
            end
        endcase

        // A taken branch squashes the ID instruction, so a concurrent load-use is moot.
        if (advance) begin
            if (branch_taken) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                pipe_en     = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                flush_inc   = 1'b1;
            end else if (load_use) begin
                pipe_en     = 1'b1;
                idex_bubble = 1'b1;
                stall_inc   = 1'b1;
            end else begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                pipe_en     = 1'b1;
            end
        end

        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            pipe_en     = 1'b0;
            idex_bubble = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            mem_err  <= mem_err | (state_nxt == ERR);
            if (state != ERR) begin
                if (cnt_clr) begin
                    stall_cnt <= '0;
                    flush_cnt <= '0;
                end else begin
                    if (stall_inc && (stall_cnt != '1))
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    if (flush_inc && (flush_cnt != '1))
                        flush_cnt <= flush_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (TIMEOUT=4, CNT_W=2): vector table for the RUN-state
// decode plus hand sequences for memory wait, timeout and asynchronous reset.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       idex_memread;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic       ifid_use_rt, branch_taken, dmem_req, dmem_ready, cnt_clr;
    logic       pc_write, ifid_write, pipe_en, idex_bubble;
    logic       ifid_flush, idex_flush, exmem_flush, mem_err;
    logic [1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.CNT_W(2), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rt(ifid_use_rt),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .cnt_clr(cnt_clr),
        .pc_write(pc_write), .ifid_write(ifid_write), .pipe_en(pipe_en),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       memread;
        logic [4:0] ex_rt, rs, rt;
        logic       use_rt, br, req, rdy, clr;
        logic [6:0] ctl;   // {pc_write, ifid_write, pipe_en, idex_bubble, ifid_flush, idex_flush, exmem_flush}
        logic [1:0] stall_after, flush_after;
    } vec_t;

    localparam logic [6:0] CTL_RUN   = 7'b111_0_000;
    localparam logic [6:0] CTL_STALL = 7'b001_1_000;
    localparam logic [6:0] CTL_FLUSH = 7'b111_0_111;
    localparam logic [6:0] CTL_FROZE = 7'b000_0_000;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ctl_now();
        return {pc_write, ifid_write, pipe_en, idex_bubble, ifid_flush, idex_flush, exmem_flush};
    endfunction

    task automatic drive(input vec_t v);
        idex_memread = v.memread;
        idex_rt      = v.ex_rt;
        ifid_rs      = v.rs;
        ifid_rt      = v.rt;
        ifid_use_rt  = v.use_rt;
        branch_taken = v.br;
        dmem_req     = v.req;
        dmem_ready   = v.rdy;
        cnt_clr      = v.clr;
    endtask

    task automatic idle();
        idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0; ifid_use_rt = 0;
        branch_taken = 0; dmem_req = 0; dmem_ready = 0; cnt_clr = 0;
    endtask

    initial begin
        //          mrd ex_rt rs  rt use br req rdy clr ctl        stall flush
        vecs[0]  = '{0, 0,    0,  0, 0,  0, 0,  0,  0,  CTL_RUN,   2'd0, 2'd0};
        vecs[1]  = '{1, 5,    5,  0, 0,  0, 0,  0,  0,  CTL_STALL, 2'd1, 2'd0};
        vecs[2]  = '{1, 0,    0,  0, 0,  0, 0,  0,  0,  CTL_RUN,   2'd1, 2'd0};
        vecs[3]  = '{1, 7,    3,  7, 0,  0, 0,  0,  0,  CTL_RUN,   2'd1, 2'd0};
        vecs[4]  = '{1, 7,    3,  7, 1,  0, 0,  0,  0,  CTL_STALL, 2'd2, 2'd0};
        vecs[5]  = '{1, 5,    5,  0, 0,  1, 0,  0,  0,  CTL_FLUSH, 2'd2, 2'd1};
        vecs[6]  = '{0, 0,    0,  0, 0,  0, 1,  1,  0,  CTL_RUN,   2'd2, 2'd1};
        vecs[7]  = '{1, 5,    5,  0, 0,  0, 1,  1,  0,  CTL_STALL, 2'd3, 2'd1};
        vecs[8]  = '{1, 5,    5,  0, 0,  0, 0,  0,  0,  CTL_STALL, 2'd3, 2'd1};
        vecs[9]  = '{1, 5,    5,  0, 0,  0, 0,  0,  1,  CTL_STALL, 2'd0, 2'd0};
        vecs[10] = '{0, 0,    0,  0, 0,  1, 0,  0,  0,  CTL_FLUSH, 2'd0, 2'd1};
        vecs[11] = '{0, 5,    5,  0, 0,  0, 0,  0,  0,  CTL_RUN,   2'd0, 2'd1};

        idle();
        reset = 1'b1;
        #2;
        check("reset_ctl", 32'(ctl_now()), 32'(CTL_FROZE));
        check("reset_mem_err", 32'(mem_err), 0);
        check("reset_stall_cnt", 32'(stall_cnt), 0);
        check("reset_flush_cnt", 32'(flush_cnt), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
            @(posedge clk); #1;
            check($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].stall_after));
            check($sformatf("vec%0d_flush_cnt", i), 32'(flush_cnt), 32'(vecs[i].flush_after));
        end

        // Memory wait of three cycles, completing together with a taken branch.
        idle();
        dmem_req = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("wait%0d_ctl", c), 32'(ctl_now()), 32'(CTL_FROZE));
            @(posedge clk); #1;
        end
        dmem_ready = 1; branch_taken = 1;
        @(negedge clk);
        check("wait_ready_ctl", 32'(ctl_now()), 32'(CTL_FLUSH));
        @(posedge clk); #1;
        check("wait_ready_flush_cnt", 32'(flush_cnt), 2);
        idle();
        @(negedge clk);
        check("after_wait_ctl", 32'(ctl_now()), 32'(CTL_RUN));
        check("after_wait_mem_err", 32'(mem_err), 0);
        @(posedge clk); #1;

        // Timeout: four frozen cycles, then sticky error.
        dmem_req = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("to%0d_ctl", c), 32'(ctl_now()), 32'(CTL_FROZE));
            check($sformatf("to%0d_mem_err", c), 32'(mem_err), 0);
            @(posedge clk); #1;
        end
        check("timeout_mem_err", 32'(mem_err), 1);
        dmem_ready = 1; branch_taken = 1; cnt_clr = 1;
        idex_memread = 1; idex_rt = 5; ifid_rs = 5;
        @(negedge clk);
        check("err_ctl", 32'(ctl_now()), 32'(CTL_FROZE));
        check("err_mem_err", 32'(mem_err), 1);
        @(posedge clk); #1;
        check("err_mem_err_sticky", 32'(mem_err), 1);
        check("err_flush_cnt_held", 32'(flush_cnt), 2);
        check("err_stall_cnt_held", 32'(stall_cnt), 0);

        // Asynchronous reset pulse out of ERR.
        idle();
        #2 reset = 1'b1;
        #1;
        check("areset_mem_err", 32'(mem_err), 0);
        check("areset_flush_cnt", 32'(flush_cnt), 0);
        check("areset_ctl", 32'(ctl_now()), 32'(CTL_FROZE));
        #1 reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("post_reset_ctl", 32'(ctl_now()), 32'(CTL_RUN));
        check("post_reset_mem_err", 32'(mem_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
